terrain_level_loader: RTL

- Sequences level construction for the terrain entity pool: on a load request, kills every live terrain entity, then walks a level table in ROM.
- For each table entry it issues exactly one spawn strobe to the jungle, wall or water entity group, with terrainID and spawnArea driven on a shared broadcast bus.
- Sits between the game-state controller (load requests) and the terrain entity instances (sigKill, spawn strobes, terrainID and spawnArea inputs).

---
 rtl/terrain_pkg.sv | 42 ++++
 rtl/terrain_level_loader_spawn.sv | 40 ++++
 rtl/terrain_level_loader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/terrain_pkg.sv
// Shared types for the terrain level loader: geometry, terrain kinds,
// the ROM level-entry layout and the loader state encoding.
package terrain_pkg;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } POSITION;

    typedef struct packed {
        POSITION center;
        POSITION radius;
    } RECT;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        JUNGLE = 2'd1,
        WALL   = 2'd2,
        WATER  = 2'd3
    } TERRAIN_KIND;

    typedef struct packed {
        logic        isEnd;
        TERRAIN_KIND kind;
        logic [7:0]  terrainID;
        RECT         area;
    } LEVEL_ENTRY;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KILL,
        S_FETCH,
        S_WAIT,
        S_SPAWN,
        S_FINISH
    } load_state_t;

    function automatic logic is_spawn(input LEVEL_ENTRY e);
        return !e.isEnd && (e.kind != NONE);
    endfunction

endpackage

// File: rtl/terrain_level_loader_spawn.sv
// Spawn output stage: decodes the ROM entry as it arrives and registers
// the strobes together with the broadcast terrainID/spawnArea bus.
module terrain_level_loader_spawn
    import terrain_pkg::*;
(
    input  logic       clk,
    input  logic       reset_l,
    input  logic       load,
    input  LEVEL_ENTRY entry,
    output logic       jungle,
    output logic       wall,
    output logic       water,
    output logic [7:0] id,
    output RECT        area
);

    logic fire;

    assign fire = load && is_spawn(entry);

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            jungle <= 1'b0;
            wall   <= 1'b0;
            water  <= 1'b0;
            id     <= '0;
            area   <= '0;
        end else begin
            jungle <= fire && (entry.kind == JUNGLE);
            wall   <= fire && (entry.kind == WALL);
            water  <= fire && (entry.kind == WATER);
            // The bus holds its last value between spawns.
            if (fire) begin
                id   <= entry.terrainID;
                area <= entry.area;
            end
        end
    end

endmodule

// File: rtl/terrain_level_loader.sv
// Level loader: on request kills all terrain entities, then walks one level
// slot of the level ROM issuing one spawn strobe per entry until END.
module terrain_level_loader
    import terrain_pkg::*;
#(
    parameter int MAX_ENTRIES = 64,
    parameter int LEVEL_BITS  = 2,
    parameter int ADDR_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  reset_l,
    input  logic                  loadReq,
    input  logic [LEVEL_BITS-1:0] levelSel,
    output logic [ADDR_BITS-1:0]  romAddr,
    input  LEVEL_ENTRY            romData,
    output logic                  sigKill,
    output logic                  spawnJungle,
    output logic                  spawnWall,
    output logic                  spawnWater,
    output logic [7:0]            terrainID,
    output RECT                   spawnArea,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_BITS-1:0]  spawnCount,
    output logic                  overflow
);

    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(MAX_ENTRIES - 1);

    load_state_t          state;
    load_state_t          state_next;
    logic [ADDR_BITS-1:0] base;
    logic [ADDR_BITS-1:0] idx;
    logic [ADDR_BITS-1:0] spawn_count;
    logic                 overflow_flag;
    logic                 end_flag;
    logic                 spawned;

    assign romAddr    = base + idx;
    assign spawnCount = spawn_count;
    assign overflow   = overflow_flag;
    assign spawned    = spawnJungle | spawnWall | spawnWater;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sigKill    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (loadReq) begin
                    state_next = S_KILL;
                end
            end
            S_KILL: begin
                sigKill    = 1'b1;
                state_next = S_FETCH;
            end
            S_FETCH: state_next = S_WAIT;
            S_WAIT:  state_next = S_SPAWN;
            S_SPAWN: begin
                if (end_flag || (idx == LAST_IDX)) begin
                    state_next = S_FINISH;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_FINISH: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            base          <= '0;
            idx           <= '0;
            spawn_count   <= '0;
            overflow_flag <= 1'b0;
            end_flag      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (loadReq) begin
                        base          <= ADDR_BITS'(levelSel) * ADDR_BITS'(MAX_ENTRIES);
                        idx           <= '0;
                        spawn_count   <= '0;
                        overflow_flag <= 1'b0;
                    end
                end
                S_WAIT: end_flag <= romData.isEnd;
                S_SPAWN: begin
                    if (spawned) begin
                        spawn_count <= spawn_count + ADDR_BITS'(1);
                    end
                    // A full slot without END is reported rather than
                    // letting the walk run into the next level.
                    if (!end_flag) begin
                        if (idx == LAST_IDX) begin
                            overflow_flag <= 1'b1;
                        end else begin
                            idx <= idx + ADDR_BITS'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    terrain_level_loader_spawn u_spawn (
        .clk     (clk),
        .reset_l (reset_l),
        .load    (state == S_WAIT),
        .entry   (romData),
        .jungle  (spawnJungle),
        .wall    (spawnWall),
        .water   (spawnWater),
        .id      (terrainID),
        .area    (spawnArea)
    );

endmodule
